fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port among NUM_REQ independent producers. Each producer presents a valid/ready/last stream. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `w_data`/`w_en` from the granted producer. It also honours the FIFO `full` flag, so no beat is lost or duplicated. It sits between the producer blocks and the FIFO.

## Interface
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `DATA_WIDTH`, default 32: beat width; equals the FIFO `DATA_WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1.
- `ID_WIDTH`, default max(1, $clog2(NUM_REQ)): width of the grant index (localparam).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  marks the final beat of a requester's packet.
- `req_ready`  out  NUM_REQ  beat accepted from requester i when `req_valid[i] && req_ready[i]`.
- `fifo_w_data`  out  DATA_WIDTH  to FIFO `w_data`.
- `fifo_w_en`  out  1  to FIFO `w_en`.
- `fifo_full`  in  1  from FIFO `full`.
- `grant_id`  out  ID_WIDTH  index of the current or last grantee (registered).
- `busy`  out  1  high while in the GRANT state.

## Operation
- The FSM has two states: IDLE and GRANT. Registered state: `state`, `grant_id`, `rr_ptr` (ID_WIDTH), `beat_cnt` ($clog2(MAX_BURST+1) bits).
- **IDLE:**
  - `req_ready`=0 and `fifo_w_en`=0.
  - When any `req_valid` is set and `fifo_full`=0, select the first set `req_valid[i]` scanning i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register that index into `grant_id`, clear `beat_cnt`, and go to GRANT.
- **GRANT** (g = `grant_id`):
  - `req_ready[g]` = !fifo_full; all other `req_ready` bits are 0.
  - `fifo_w_en` = req_valid[g] && !fifo_full.
  - `fifo_w_data` = req_data[g] in every state; it is don't-care when `fifo_w_en`=0.
  - A transfer happens when `fifo_w_en`=1. On each transfer, `beat_cnt` increments.
- **Release:** go GRANT→IDLE at the end of a cycle when any of the following holds:
  - (a) a transfer occurs with `req_last[g]`=1;
  - (b) a transfer occurs with `beat_cnt`+1 == MAX_BURST;
  - (c) `req_valid[g]`=0.
- On release, `rr_ptr` ← (g+1) mod NUM_REQ, computed at explicit ID width. The wrap from NUM_REQ-1 to 0 is required for non-power-of-2 NUM_REQ.
- A FIFO stall (`fifo_full`=1 with `req_valid[g]`=1) holds the grant. The stall does not count a beat and does not release.
- Non-granted requesters are never acknowledged. Their data must be held by the requester.
- With NUM_REQ=1, the arbiter always regrants requester 0.
- With MAX_BURST=1, every grant carries exactly one beat.

## Timing
- **Reset values** (asserted asynchronously, immediately on `rst`):
  - `state`=IDLE, `grant_id`=0, `rr_ptr`=0, `beat_cnt`=0.
  - `busy`=0, `req_ready`=0, `fifo_w_en`=0.
- **Reset mid-burst:** the burst is abandoned, with no further `fifo_w_en`. After `rst` deasserts, arbitration restarts from requester 0.
- **Arbitration latency:** one cycle. A `req_valid` first seen in IDLE at edge N gives `busy`=1 and `req_ready` possible in cycle N+1.
- **Re-arbitration bubble:** one IDLE cycle after every release, so there is no back-to-back grant.
- **Minimum cycles** for a packet of k beats (k ≤ MAX_BURST) with no stall: 1 + k.
- `req_ready` and `fifo_w_en` are combinational from `state`, `grant_id`, `req_valid`, and `fifo_full`. There is no combinational path from `req_data` to control.
- **fifo_full in IDLE:** if `fifo_full`=1 in IDLE, no grant is issued even with valid requests. The arbiter stays in IDLE.
- **Simultaneous conditions:** when release conditions (a) and (b) coincide, one release occurs.
- The FIFO's one-cycle `full` update is tolerated because `w_en` is always qualified by the current `full`.

## Test plan
- **Reset and idle:** assert `rst` with all `req_valid`=1 → `busy`=0, `req_ready`=0, `fifo_w_en`=0, `grant_id`=0. Release `rst` → grant to requester 0 one cycle later.
- **Round-robin fairness:** NUM_REQ=4, all four requesters stream continuously with `req_last`=0 and MAX_BURST=4 → grant order 0,1,2,3,0. Each grant carries exactly 4 beats, with one idle cycle between grants. The FIFO receives 16 beats in 20 cycles.
- **Packet end:** requester 2 sends 2 beats (0xA, 0xB with last) while requester 3 is valid → grant 2 writes 0xA, 0xB, then IDLE, then grant_id=3. `rr_ptr` wraps so that the next grant after 3 goes to 0.
- **FIFO stall:** during grant to requester 1, hold `fifo_full`=1 for 3 cycles mid-burst → `req_ready[1]`=0 and `fifo_w_en`=0 for those cycles, the grant is held, and `beat_cnt` is unchanged. The burst completes with all beats in order and no duplicates.
- **Valid drop and full-in-idle:** granted requester deasserts `req_valid` after 1 beat → release next edge. With `fifo_full`=1 in IDLE and requests pending → no grant until `fifo_full`=0.
- **Reset mid-burst:** assert `rst` after 2 of 4 beats → outputs return to reset values within the same cycle. After release, arbitration starts at requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ valid/ready/last producers. A grant lasts until the packet ends,
// MAX_BURST beats have moved, or the grantee drops valid. Every release is
// followed by one IDLE cycle before the next grant.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   output logic                          fifo_w_en,
   input  logic                          fifo_full,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
   localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);
   localparam logic [CNT_WIDTH-1:0] BURST_LEN = CNT_WIDTH'(MAX_BURST);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

   logic [ID_WIDTH-1:0]   pick_id;
   logic                  pick_vld;
   logic [ID_WIDTH-1:0]   scan_id;
   logic                  gnt_valid;
   logic                  gnt_last;
   logic                  xfer;

   assign gnt_valid = req_valid[grant_id_q];
   assign gnt_last  = req_last[grant_id_q];
   assign grant_id  = grant_id_q;

   // Round-robin scan: first valid requester starting at rr_ptr, with explicit
   // wrap so non-power-of-2 NUM_REQ never visits an unused index.
   always_comb begin
      pick_id  = '0;
      pick_vld = 1'b0;
      scan_id  = rr_ptr_q;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!pick_vld && req_valid[scan_id]) begin
            pick_vld = 1'b1;
            pick_id  = scan_id;
         end
         scan_id = (scan_id == LAST_ID) ? '0 : scan_id + ID_WIDTH'(1);
      end
   end

   // State register: asynchronous reset abandons any burst in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Next-state: grant from IDLE when the FIFO has room, release on packet
   // end, burst limit or a dropped valid (one release even if several hold).
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld && !fifo_full) begin
               state_d    = GRANT;
               grant_id_d = pick_id;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (xfer) begin
               beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            end
            if ((xfer && (gnt_last || (beat_cnt_q + CNT_WIDTH'(1)) == BURST_LEN)) ||
                !gnt_valid) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: handshake and write enable are qualified by the current full
   // flag; the data mux depends only on grant_id, never feeding control.
   always_comb begin
      req_ready   = '0;
      fifo_w_en   = 1'b0;
      busy        = (state_q == GRANT);
      fifo_w_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_WIDTH'(i)) begin
            fifo_w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (state_q == GRANT) begin
         req_ready[grant_id_q] = !fifo_full;
         fifo_w_en             = gnt_valid && !fifo_full;
      end
      xfer = fifo_w_en;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a per-cycle behavioural model of
// the grant/burst rules, directed scenarios with literal expectations, and a
// long randomized run.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MB = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   fifo_w_data;
   logic            fifo_w_en;
   logic            fifo_full;
   logic [IW-1:0]   grant_id;
   logic            busy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ   (N),
      .DATA_WIDTH(DW),
      .MAX_BURST (MB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_w_data(fifo_w_data),
      .fifo_w_en  (fifo_w_en),
      .fifo_full  (fifo_full),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;

   // model state: who owns the port, where the next scan starts, beats so far
   bit            m_busy;
   int            m_gid;
   int            m_ptr;
   int            m_beats;
   logic [DW-1:0] cnt [N];     // next beat value each requester presents
   int            beat_log[$]; // model grantee of every expected write
   int            dut_wen;     // writes observed on the DUT port

   logic          s_wen, s_busy;
   logic [DW-1:0] s_data;
   logic [N-1:0]  s_ready;
   logic [IW-1:0] s_gid;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: present data, compare outputs at mid-cycle, advance model.
   task automatic step();
      logic [N-1:0] er;
      logic         ew;
      int           pick;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = cnt[i];
      #4;
      if (rst) begin
         m_busy  = 0;
         m_gid   = 0;
         m_ptr   = 0;
         m_beats = 0;
      end
      s_wen   = fifo_w_en;
      s_busy  = busy;
      s_data  = fifo_w_data;
      s_ready = req_ready;
      s_gid   = grant_id;
      if (fifo_w_en === 1'b1) dut_wen++;
      er = '0;
      ew = 1'b0;
      if (m_busy) begin
         if (!fifo_full) er[m_gid] = 1'b1;
         ew = req_valid[m_gid] && !fifo_full;
      end
      chk("busy", 64'(busy), 64'(m_busy));
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("fifo_w_en", 64'(fifo_w_en), 64'(ew));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      if (ew) chk("fifo_w_data", 64'(fifo_w_data), 64'(cnt[m_gid]));
      for (int i = 0; i < N; i++) if (req_valid[i] && er[i]) cnt[i] = cnt[i] + 1;
      if (ew) beat_log.push_back(m_gid);
      if (!rst) begin
         if (!m_busy) begin
            if (req_valid != '0 && !fifo_full) begin
               pick = -1;
               for (int k = 0; k < N; k++)
                  if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
               m_busy  = 1;
               m_gid   = pick;
               m_beats = 0;
            end
         end else begin
            if (ew) m_beats++;
            if ((ew && (req_last[m_gid] || m_beats == MB)) || !req_valid[m_gid]) begin
               m_busy = 0;
               m_ptr  = (m_gid + 1) % N;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [N-1:0] v);
      rst       = 1'b1;
      req_valid = v;
      req_last  = '0;
      fifo_full = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n0;
      int w0;
      for (int i = 0; i < N; i++) cnt[i] = DW'(i) << 28;
      dut_wen = 0;

      // reset with every requester valid, then first grant goes to 0
      rst = 1'b1; req_valid = '1; req_last = '0; fifo_full = 1'b0;
      step();
      chk("rst_busy", 64'(s_busy), 64'd0);
      chk("rst_ready", 64'(s_ready), 64'd0);
      chk("rst_wen", 64'(s_wen), 64'd0);
      chk("rst_gid", 64'(s_gid), 64'd0);
      rst = 1'b0;
      step();
      step();
      chk("first_grant_busy", 64'(s_busy), 64'd1);
      chk("first_grant_gid", 64'(s_gid), 64'd0);

      // round robin: all streaming, no last -> 16 beats in 20 cycles, 0..3
      do_reset('1);
      n0 = beat_log.size();
      w0 = dut_wen;
      repeat (20) step();
      chk("rr_model_beats", 64'(beat_log.size() - n0), 64'd16);
      chk("rr_dut_beats", 64'(dut_wen - w0), 64'd16);
      for (int b = 0; b < 16; b++) chk("rr_order", 64'(beat_log[n0 + b]), 64'(b / 4));
      step();
      step();
      chk("rr_wrap_busy", 64'(s_busy), 64'd1);
      chk("rr_wrap_gid", 64'(s_gid), 64'd0);

      // packet end: req 2 sends 0xA, 0xB(last); then 3; then wrap to 0
      do_reset('0);
      cnt[2] = 32'hA;
      req_valid = 4'b1100;
      step();
      step();
      chk("pkt_b0_wen", 64'(s_wen), 64'd1);
      chk("pkt_b0_data", 64'(s_data), 64'hA);
      chk("pkt_b0_gid", 64'(s_gid), 64'd2);
      req_last[2] = 1'b1;
      step();
      chk("pkt_b1_wen", 64'(s_wen), 64'd1);
      chk("pkt_b1_data", 64'(s_data), 64'hB);
      req_valid = 4'b1000;
      req_last  = 4'b1000;
      step();
      chk("pkt_bubble", 64'(s_busy), 64'd0);
      step();
      chk("pkt_next_gid", 64'(s_gid), 64'd3);
      chk("pkt_next_wen", 64'(s_wen), 64'd1);
      req_valid = '1;
      req_last  = '0;
      step();
      step();
      chk("pkt_wrap_gid", 64'(s_gid), 64'd0);
      chk("pkt_wrap_busy", 64'(s_busy), 64'd1);

      // FIFO stall of 3 cycles mid-burst of requester 1
      do_reset('0);
      req_valid = 4'b0010;
      w0 = dut_wen;
      step();
      step();
      fifo_full = 1'b1;
      repeat (3) begin
         step();
         chk("stall_wen", 64'(s_wen), 64'd0);
         chk("stall_ready", 64'(s_ready), 64'd0);
         chk("stall_busy", 64'(s_busy), 64'd1);
         chk("stall_gid", 64'(s_gid), 64'd1);
      end
      fifo_full = 1'b0;
      repeat (3) step();
      chk("stall_beats", 64'(dut_wen - w0), 64'd4);
      step();
      chk("stall_release", 64'(s_busy), 64'd0);

      // valid drop after one beat, then full held in IDLE
      do_reset('0);
      req_valid = 4'b0001;
      step();
      step();
      req_valid = '0;
      step();
      chk("drop_wen", 64'(s_wen), 64'd0);
      chk("drop_busy", 64'(s_busy), 64'd1);
      req_valid = 4'b0110;
      fifo_full = 1'b1;
      repeat (3) begin
         step();
         chk("full_idle_busy", 64'(s_busy), 64'd0);
      end
      fifo_full = 1'b0;
      step();
      step();
      chk("full_idle_grant", 64'(s_busy), 64'd1);
      chk("full_idle_gid", 64'(s_gid), 64'd1);

      // reset mid-burst of requester 1; restart from requester 0
      do_reset('0);
      req_valid = 4'b0001;
      req_last  = 4'b0001;
      step();
      step();
      req_valid = '1;
      req_last  = '0;
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_wen", 64'(fifo_w_en), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd0);
      chk("midrst_gid", 64'(grant_id), 64'd0);
      step();
      rst = 1'b0;
      step();
      step();
      chk("midrst_restart_gid", 64'(s_gid), 64'd0);
      chk("midrst_restart_busy", 64'(s_busy), 64'd1);

      // randomized traffic against the model
      do_reset('0);
      repeat (3000) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom_range(0, 9) < 7);
            req_last[i]  = ($urandom_range(0, 3) == 0);
         end
         fifo_full = ($urandom_range(0, 4) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
